// File: rtl/imem_boot_loader_if.sv
// Host byte stream + instruction-memory write port + load status of imem_boot_loader.
// slave = loader side, master = host/memory side.
interface imem_boot_loader_if #(
  parameter int MEM_SIZE = 16384
);
  localparam int ADDR_SIZE = $clog2(MEM_SIZE);

  logic                 Load_Start;
  logic [7:0]           Rx_Data;
  logic                 Rx_Valid;
  logic                 Rx_Ready;
  logic                 Mem_Wr_En;
  logic [ADDR_SIZE-1:0] Mem_Wr_Addr;
  logic [31:0]          Mem_Wr_Data;
  logic                 Core_Hold;
  logic                 Load_Done;
  logic                 Load_Error;
  logic [ADDR_SIZE:0]   Word_Count;

  modport slave (
    input  Load_Start, Rx_Data, Rx_Valid,
    output Rx_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data,
           Core_Hold, Load_Done, Load_Error, Word_Count
  );

  modport master (
    output Load_Start, Rx_Data, Rx_Valid,
    input  Rx_Ready, Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data,
           Core_Hold, Load_Done, Load_Error, Word_Count
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Byte-stream instruction memory loader: LE word count, then LE words, hart held during load.
// Optional trailing mod-256 checksum byte when CHECKSUM_EN is defined.
module imem_boot_loader #(
  parameter int DWIDTH         = 32,
  parameter int MEM_SIZE       = 16384,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic Clk_Core,
  input  logic Rst_Core_N,
  imem_boot_loader_if.slave bus
);
  localparam int ADDR_SIZE = $clog2(MEM_SIZE);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
`ifdef CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [ADDR_SIZE:0]   len_q, len_d;
  logic [DWIDTH-1:0]    word_q, word_d, word_nx;
  logic [ADDR_SIZE:0]   wc_q, wc_d, wc_inc;
  logic [TW-1:0]        to_q, to_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]          wr_data_q, wr_data_d;
  logic                 hold_q, done_q, done_d, err_q, err_d;
  logic                 busy, accept, fin;
`ifdef CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  assign busy   = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef CHECKSUM_EN
               || (state_q == S_CHK)
`endif
               ;
  assign accept = bus.Rx_Valid && busy;
  assign wc_inc = wc_q + (ADDR_SIZE+1)'(1);

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    word_d    = word_q;
    wc_d      = wc_q;
    to_d      = to_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    err_d     = err_q;
    fin       = 1'b0;
`ifdef CHECKSUM_EN
    sum_d     = sum_q;
`endif
    word_nx   = word_q;
    word_nx[{bcnt_q, 3'b000} +: 8] = bus.Rx_Data;
    if (busy) to_d = accept ? '0 : to_q + TW'(1);

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.Load_Start) begin
          state_d = S_LEN;
          done_d  = 1'b0;
          err_d   = 1'b0;
          wc_d    = '0;
          bcnt_d  = '0;
          to_d    = '0;
`ifdef CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
          word_d = word_nx;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            len_d = word_nx[ADDR_SIZE:0];
            if (word_nx == '0) fin = 1'b1;
            else if (word_nx > DWIDTH'(MEM_SIZE)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          word_d = word_nx;
          bcnt_d = bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
          sum_d  = sum_q + bus.Rx_Data;
`endif
          // The word is registered here so the strobe lands the cycle after the 4th byte.
          if (bcnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wc_q[ADDR_SIZE-1:0];
            wr_data_d = word_nx;
            wc_d      = wc_inc;
            if (wc_inc == len_q) fin = 1'b1;
          end
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (accept) begin
          if (bus.Rx_Data == sum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
`ifdef CHECKSUM_EN
      state_d = S_CHK;
`else
      state_d = S_DONE;
      done_d  = 1'b1;
`endif
    end

    // A stalled partial word is simply dropped; nothing is written on timeout.
    if (busy && !accept && to_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (!Rst_Core_N) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      len_q     <= '0;
      word_q    <= '0;
      wc_q      <= '0;
      to_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      len_q     <= len_d;
      word_q    <= word_d;
      wc_q      <= wc_d;
      to_q      <= to_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= busy || (state_q == S_ERR);
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  assign bus.Rx_Ready    = busy;
  assign bus.Mem_Wr_En   = wr_en_q;
  assign bus.Mem_Wr_Addr = wr_addr_q;
  assign bus.Mem_Wr_Data = wr_data_q;
  assign bus.Core_Hold   = hold_q;
  assign bus.Load_Done   = done_q;
  assign bus.Load_Error  = err_q;
  assign bus.Word_Count  = wc_q;
endmodule
